log2_normalize: RTL and testbench



---
 rtl/log2_pkg.sv | 21 ++
 rtl/log2_normalize_if.sv | 25 ++
 rtl/log2_norm_round.sv | 51 +++++
 rtl/log2_normalize.sv | 103 ++++++++++
 tb/tb_log2_normalize.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/log2_pkg.sv
// Shared constants and types for the log2 datapath front end.
// Exp width carries one extra bit for the round-up carry out of the fraction.
package log2_pkg;

    localparam int unsigned LOG2_OP_W   = 32;
    localparam int unsigned LOG2_FRAC_W = 23;
    localparam int unsigned LOG2_IDX_W  = 6;

    function automatic int unsigned log2_exp_w(input int unsigned op_w);
        return $clog2(op_w) + 1;
    endfunction

    localparam int unsigned LOG2_EXP_W = log2_exp_w(LOG2_OP_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } log2_norm_state_t;

endpackage

// File: rtl/log2_normalize_if.sv
// Operand/result handshake bundle between the producer, the normalizer and the log2 stage.
interface log2_normalize_if #(
    parameter int unsigned OP_W   = log2_pkg::LOG2_OP_W,
    parameter int unsigned FRAC_W = log2_pkg::LOG2_FRAC_W,
    parameter int unsigned EXP_W  = log2_pkg::log2_exp_w(OP_W)
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic              out_valid;
    logic              out_ready;
    logic [FRAC_W-1:0] out_frac;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;

    modport master (
        output in_valid, in_op, out_ready,
        input  in_ready, out_valid, out_frac, out_exp, out_zero
    );

    modport slave (
        input  in_valid, in_op, out_ready,
        output in_ready, out_valid, out_frac, out_exp, out_zero
    );
endinterface

// File: rtl/log2_norm_round.sv
// Combinational result formation from the normalized operand and leading-zero count.
// Define LOG2_NORM_ROUND_EN for round half-up; otherwise the fraction is truncated.
module log2_norm_round #(
    parameter int unsigned OP_W   = 32,
    parameter int unsigned FRAC_W = 23,
    parameter int unsigned EXP_W  = 6
) (
    input  logic [OP_W-1:0]   sr,
    input  logic [EXP_W-1:0]  lzc,
    output logic [FRAC_W-1:0] frac_c,
    output logic [EXP_W-1:0]  exp_c,
    output logic              zero_c
);
    logic [FRAC_W-1:0] trunc;
    logic [EXP_W-1:0]  exp_raw;
    logic [FRAC_W-1:0] frac_r;
    logic [EXP_W-1:0]  exp_r;
    logic              unused_lsbs;

    // A normalized nonzero operand always has its MSB set.
    assign zero_c      = ~sr[OP_W-1];
    assign trunc       = sr[OP_W-2 -: FRAC_W];
    assign exp_raw     = EXP_W'(OP_W - 1) - lzc;
    assign unused_lsbs = ^sr[OP_W-FRAC_W-2:0];

`ifdef LOG2_NORM_ROUND_EN
    logic [FRAC_W:0] sum;

    assign sum = {1'b0, trunc} + (FRAC_W+1)'(sr[OP_W-2-FRAC_W]);

    // Carry out wraps the fraction to zero and bumps the characteristic.
    always_comb begin
        frac_r = sum[FRAC_W-1:0];
        exp_r  = exp_raw + EXP_W'(sum[FRAC_W]);
    end
`else
    always_comb begin
        frac_r = trunc;
        exp_r  = exp_raw;
    end
`endif

    always_comb begin
        frac_c = frac_r;
        exp_c  = exp_r;
        if (zero_c) begin
            frac_c = '0;
            exp_c  = '0;
        end
    end
endmodule

// File: rtl/log2_normalize.sv
// Fixed-latency leading-one normalizer feeding the table-driven log2 mantissa stage.
// Rounding is selected by LOG2_NORM_ROUND_EN inside log2_norm_round.
module log2_normalize
    import log2_pkg::*;
#(
    parameter int unsigned OP_W   = LOG2_OP_W,
    parameter int unsigned FRAC_W = LOG2_FRAC_W
) (
    input  logic clk,
    input  logic rst_n,
    log2_normalize_if.slave bus
);
    localparam int unsigned EXP_W  = log2_exp_w(OP_W);
    localparam int unsigned STEPS  = $clog2(OP_W);
    localparam int unsigned STEP_W = $clog2(STEPS);

    log2_norm_state_t  state, state_nx;
    logic [OP_W-1:0]   sr, sr_nx;
    logic [EXP_W-1:0]  lzc, lzc_nx;
    logic [STEP_W-1:0] step, step_nx;
    logic [EXP_W-1:0]  k;
    logic              latch;
    logic [FRAC_W-1:0] frac_c;
    logic [EXP_W-1:0]  exp_c;
    logic              zero_c;

    // Binary-search step: shift by k when the top k bits are all zero.
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        lzc_nx   = lzc;
        step_nx  = step;
        k        = '0;
        latch    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_nx    = bus.in_op;
                    lzc_nx   = '0;
                    step_nx  = '0;
                    state_nx = NORM;
                end
            end
            NORM: begin
                k = EXP_W'(OP_W >> (32'(step) + 32'd1));
                if ((sr >> (OP_W - 32'(k))) == '0) begin
                    sr_nx  = sr << k;
                    lzc_nx = lzc + k;
                end
                step_nx = step + STEP_W'(1);
                if (step == STEP_W'(STEPS - 1)) begin
                    state_nx = DONE;
                    latch    = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result is formed from the post-step value so it latches on the final NORM edge.
    log2_norm_round #(
        .OP_W   (OP_W),
        .FRAC_W (FRAC_W),
        .EXP_W  (EXP_W)
    ) u_round (
        .sr     (sr_nx),
        .lzc    (lzc_nx),
        .frac_c (frac_c),
        .exp_c  (exp_c),
        .zero_c (zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sr            <= '0;
            lzc           <= '0;
            step          <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_frac  <= '0;
            bus.out_exp   <= '0;
            bus.out_zero  <= 1'b0;
        end else begin
            state         <= state_nx;
            sr            <= sr_nx;
            lzc           <= lzc_nx;
            step          <= step_nx;
            bus.in_ready  <= (state_nx == IDLE);
            bus.out_valid <= (state_nx == DONE);
            if (latch) begin
                bus.out_frac <= frac_c;
                bus.out_exp  <= exp_c;
                bus.out_zero <= zero_c;
            end
        end
    end
endmodule

// File: tb/tb_log2_normalize.sv
// Directed bench for log2_normalize; expected values are hand-computed constants.
// Build with LOG2_NORM_ROUND_EN defined to check the rounding variant.
module tb_log2_normalize;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   lat;
    logic [22:0] hold_frac;
    logic [5:0]  hold_exp;
    logic        hold_zero;

    log2_normalize_if bus ();

    log2_normalize dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Present one operand for one accept edge.
    task automatic send(input logic [31:0] op);
        chk("in_ready_before_send", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        step_clk();
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int c = 1; c <= 20; c++) begin
            step_clk();
            if (bus.out_valid) begin
                l = c;
                break;
            end
        end
        chk("latency", 64'(l), 64'd5);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        step_clk();
        bus.out_ready = 1'b0;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] op, input logic [5:0] e_exp,
                       input logic [22:0] e_frac, input logic e_zero);
        int l;
        send(op);
        wait_done(l);
        chk({tag, "_exp"}, 64'(bus.out_exp), 64'(e_exp));
        chk({tag, "_frac"}, 64'(bus.out_frac), 64'(e_frac));
        chk({tag, "_zero"}, 64'(bus.out_zero), 64'(e_zero));
        release_out();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_frac", 64'(bus.out_frac), 64'd0);
        chk("rst_out_exp", 64'(bus.out_exp), 64'd0);
        chk("rst_out_zero", 64'(bus.out_zero), 64'd0);
        rst_n = 1'b1;
        step_clk();
        step_clk();

        run("one", 32'h0000_0001, 6'd0, 23'h000000, 1'b0);
        run("x12345", 32'h0001_2345, 6'd16, 23'h11A280, 1'b0);
`ifdef LOG2_NORM_ROUND_EN
        run("all_ones", 32'hFFFF_FFFF, 6'd32, 23'h000000, 1'b0);
`else
        run("all_ones", 32'hFFFF_FFFF, 6'd31, 23'h7FFFFF, 1'b0);
`endif
        run("zero", 32'h0000_0000, 6'd0, 23'h000000, 1'b1);
        run("xC00000", 32'h00C0_0000, 6'd23, 23'h400000, 1'b0);

        // Backpressure: result held, new operand refused.
        send(32'h0001_2345);
        wait_done(lat);
        hold_frac = bus.out_frac;
        hold_exp  = bus.out_exp;
        hold_zero = bus.out_zero;
        chk("bp_first_exp", 64'(hold_exp), 64'd16);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i == 4);
            bus.in_op    = 32'h8000_0000;
            step_clk();
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_frac_hold", 64'(bus.out_frac), 64'h11A280);
            chk("bp_exp_hold", 64'(bus.out_exp), 64'd16);
            chk("bp_zero_hold", 64'(bus.out_zero), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        release_out();
        step_clk();
        chk("bp_pulse_dropped", 64'(bus.out_valid), 64'd0);
        run("x80000000", 32'h8000_0000, 6'd31, 23'h000000, 1'b0);

        // Leave a nonzero result on the outputs, then reset during NORM step 3.
        run("pre_rst", 32'h0001_2345, 6'd16, 23'h11A280, 1'b0);
        send(32'hFFFF_FFFF);
        step_clk();
        step_clk();
        step_clk();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_out_frac", 64'(bus.out_frac), 64'd0);
        chk("midrst_out_exp", 64'(bus.out_exp), 64'd0);
        chk("midrst_out_zero", 64'(bus.out_zero), 64'd0);
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_clk();
            chk("postrst_no_result", 64'(bus.out_valid), 64'd0);
        end
        run("x100", 32'h0000_0100, 6'd8, 23'h000000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
